mask_bbox_tracker: RTL and testbench

- Frame-level bounding-box and area accumulator.
- Consumes the binary-mask pixel stream from the morphological dilation stage: 10-bit data qualified by a valid strobe, one pixel per valid cycle, raster order.
- Tracks min/max column and row of foreground pixels and counts them.
- At end of frame, latches the results for the overlay/OSD stage and pulses a done strobe.

---
 rtl/mask_bbox_tracker.sv | 160 ++++++++++++++++
 tb/tb_mask_bbox_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mask_bbox_tracker.sv
// Frame-level bounding box and foreground area of a raster binary-mask stream.
// Results are latched at end of frame with a one-cycle done strobe.
module mask_bbox_tracker #(
  parameter int          H_ACTIVE = 800,
  parameter int          V_ACTIVE = 600,
  parameter logic [9:0]  THRESH   = 10'd512,
  parameter int          CW       = 12,
  parameter int          AW       = 20
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          iSOF,
  input  logic          iDVAL,
  input  logic [9:0]    input_data,
  output logic [CW-1:0] oX_MIN,
  output logic [CW-1:0] oX_MAX,
  output logic [CW-1:0] oY_MIN,
  output logic [CW-1:0] oY_MAX,
  output logic [AW-1:0] oAREA,
  output logic          oBOX_VALID,
  output logic          oFRAME_DONE
);

  // state | meaning
  // ACCUM | accumulating pixels of the current frame
  // FLUSH | strobe cycle; results already latched, working state already clear
  typedef enum logic {ACCUM, FLUSH} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] C_ONES   = '1;
  localparam logic [AW-1:0] A_ONES   = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [AW-1:0] area_q, area_d;
  logic          any_q, any_d;
  logic [CW-1:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d, oymin_q, oymin_d, oymax_q, oymax_d;
  logic [AW-1:0] oarea_q, oarea_d;
  logic          obv_q, obv_d;
  logic          eof_c, clear_c, fg_c;

  always_comb begin
    eof_c   = iDVAL && (col_q == COL_LAST) && (row_q == ROW_LAST);
    // The end-of-frame pixel wins over a coincident iSOF.
    clear_c = iSOF && !eof_c;
    fg_c    = iDVAL && (input_data >= THRESH);

    col_d  = col_q;
    row_d  = row_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    area_d = area_q;
    any_d  = any_q;

    oxmin_d = oxmin_q;
    oxmax_d = oxmax_q;
    oymin_d = oymin_q;
    oymax_d = oymax_q;
    oarea_d = oarea_q;
    obv_d   = obv_q;

    if (clear_c) begin
      col_d  = '0;
      row_d  = '0;
      xmin_d = C_ONES;
      xmax_d = '0;
      ymin_d = C_ONES;
      ymax_d = '0;
      area_d = '0;
      any_d  = 1'b0;
    end

    if (fg_c) begin
      if (col_d < xmin_d) xmin_d = col_d;
      if (col_d > xmax_d) xmax_d = col_d;
      if (row_d < ymin_d) ymin_d = row_d;
      if (row_d > ymax_d) ymax_d = row_d;
      if (area_d != A_ONES) area_d = area_d + 1'b1;
      any_d = 1'b1;
    end

    if (iDVAL) begin
      if (col_d == COL_LAST) begin
        col_d = '0;
        row_d = (row_d == ROW_LAST) ? '0 : row_d + 1'b1;
      end else begin
        col_d = col_d + 1'b1;
      end
    end

    // Latch on the end-of-frame edge so results are visible during FLUSH.
    if (eof_c) begin
      obv_d   = any_d;
      oxmin_d = any_d ? xmin_d : '0;
      oxmax_d = any_d ? xmax_d : '0;
      oymin_d = any_d ? ymin_d : '0;
      oymax_d = any_d ? ymax_d : '0;
      oarea_d = any_d ? area_d : '0;
      col_d   = '0;
      row_d   = '0;
      xmin_d  = C_ONES;
      xmax_d  = '0;
      ymin_d  = C_ONES;
      ymax_d  = '0;
      area_d  = '0;
      any_d   = 1'b0;
    end

    state_d = eof_c ? FLUSH : ACCUM;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ACCUM;
      col_q   <= '0;
      row_q   <= '0;
      xmin_q  <= C_ONES;
      xmax_q  <= '0;
      ymin_q  <= C_ONES;
      ymax_q  <= '0;
      area_q  <= '0;
      any_q   <= 1'b0;
      oxmin_q <= '0;
      oxmax_q <= '0;
      oymin_q <= '0;
      oymax_q <= '0;
      oarea_q <= '0;
      obv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      area_q  <= area_d;
      any_q   <= any_d;
      oxmin_q <= oxmin_d;
      oxmax_q <= oxmax_d;
      oymin_q <= oymin_d;
      oymax_q <= oymax_d;
      oarea_q <= oarea_d;
      obv_q   <= obv_d;
    end
  end

  assign oX_MIN      = oxmin_q;
  assign oX_MAX      = oxmax_q;
  assign oY_MIN      = oymin_q;
  assign oY_MAX      = oymax_q;
  assign oAREA       = oarea_q;
  assign oBOX_VALID  = obv_q;
  assign oFRAME_DONE = (state_q == FLUSH);

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Bench for mask_bbox_tracker on an 8x4 frame: table-driven frames, iSOF corner
// sequences, and random gapped traffic against a pixel-list reference model.
module tb_mask_bbox_tracker;
  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        dval = 1'b0;
  logic [9:0]  din = '0;
  logic [11:0] x_min, x_max, y_min, y_max;
  logic [19:0] area;
  logic        bv, done;

  always #5 clk = ~clk;

  mask_bbox_tracker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .THRESH(10'd512), .CW(12), .AW(20)
  ) u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .iSOF(sof), .iDVAL(dval), .input_data(din),
    .oX_MIN(x_min), .oX_MAX(x_max), .oY_MIN(y_min), .oY_MAX(y_max),
    .oAREA(area), .oBOX_VALID(bv), .oFRAME_DONE(done)
  );

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // Reference model: pixel index within frame plus list of foreground coordinates.
  int p = 0;
  int qx[$];
  int qy[$];
  int e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_area = 0, e_bv = 0, e_done = 0;

  typedef struct {
    logic [31:0] mask;
    logic [9:0]  fgv;
    logic [9:0]  bgv;
    int          xmin, xmax, ymin, ymax, area, bvld;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    p = 0;
    qx.delete();
    qy.delete();
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_area = 0; e_bv = 0; e_done = 0;
  endtask

  task automatic model_step(input bit s, input bit dv, input int data);
    bit eof;
    eof = dv && (p == N - 1);
    e_done = 0;
    if (s && !eof) begin
      p = 0;
      qx.delete();
      qy.delete();
    end
    if (dv) begin
      if (data >= 512) begin
        qx.push_back(p % H);
        qy.push_back(p / H);
      end
      if (eof) begin
        e_done = 1;
        if (qx.size() > 0) begin
          e_xmin = qx[0]; e_xmax = qx[0]; e_ymin = qy[0]; e_ymax = qy[0];
          foreach (qx[k]) begin
            if (qx[k] < e_xmin) e_xmin = qx[k];
            if (qx[k] > e_xmax) e_xmax = qx[k];
            if (qy[k] < e_ymin) e_ymin = qy[k];
            if (qy[k] > e_ymax) e_ymax = qy[k];
          end
          e_area = qx.size();
          e_bv = 1;
        end else begin
          e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_area = 0; e_bv = 0;
        end
        qx.delete();
        qy.delete();
        p = 0;
      end else begin
        p++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".xmin"}, x_min, e_xmin);
    chk({tag, ".xmax"}, x_max, e_xmax);
    chk({tag, ".ymin"}, y_min, e_ymin);
    chk({tag, ".ymax"}, y_max, e_ymax);
    chk({tag, ".area"}, area, e_area);
    chk({tag, ".bv"}, bv, e_bv);
  endtask

  task automatic step(input bit s, input bit dv, input logic [9:0] data, input string tag);
    @(negedge clk);
    sof = s;
    dval = dv;
    din = data;
    @(posedge clk);
    model_step(s, dv, int'(data));
    #1;
    if (done === 1'b1) strobes++;
    check_all(tag);
  endtask

  task automatic check_expected(input string tag, input int xmn, input int xmx,
                                input int ymn, input int ymx, input int ar, input int v);
    chk({tag, ".strobe"}, done, 1);
    chk({tag, ".exp_xmin"}, x_min, xmn);
    chk({tag, ".exp_xmax"}, x_max, xmx);
    chk({tag, ".exp_ymin"}, y_min, ymn);
    chk({tag, ".exp_ymax"}, y_max, ymx);
    chk({tag, ".exp_area"}, area, ar);
    chk({tag, ".exp_bv"}, bv, v);
  endtask

  initial begin
    int s0;
    logic [9:0] d;

    // bit index = row*8 + col
    tbl[0] = '{32'h0000_0000, 10'd1023, 10'd0,   0, 0, 0, 0, 0, 0};
    tbl[1] = '{(32'd1 << 10) | (32'd1 << 13) | (32'd1 << 19), 10'd1023, 10'd0, 2, 5, 1, 2, 3, 1};
    tbl[2] = '{32'h8000_0000, 10'd512,  10'd511, 7, 7, 3, 3, 1, 1};
    tbl[3] = '{32'h0000_0001, 10'd1023, 10'd0,   0, 0, 0, 0, 1, 1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back frames with iDVAL held high; each pixel 0 lands in the previous FLUSH.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        step(1'b0, 1'b1, tbl[k].mask[i] ? tbl[k].fgv : tbl[k].bgv, $sformatf("tbl%0d", k));
      check_expected($sformatf("tbl%0d", k), tbl[k].xmin, tbl[k].xmax, tbl[k].ymin,
                     tbl[k].ymax, tbl[k].area, tbl[k].bvld);
    end

    // Abort after 10 pixels, then a clean frame starting with iSOF+iDVAL.
    s0 = strobes;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, (i == 1) ? 10'd1023 : 10'd0, "abort");
    for (int i = 0; i < N; i++) step(i == 0, 1'b1, (i == 30) ? 10'd1023 : 10'd0, "clean");
    check_expected("clean", 6, 6, 3, 3, 1, 1);
    chk("abort.strobes", strobes - s0, 1);

    // iSOF on the end-of-frame pixel, then iSOF in the FLUSH cycle with a pixel.
    for (int i = 0; i < N; i++) step(i == 31, 1'b1, (i == 20) ? 10'd1023 : 10'd0, "sofeof");
    check_expected("sofeof", 4, 4, 2, 2, 1, 1);
    for (int i = 0; i < N; i++) step(i == 0, 1'b1, (i == 0 || i == 9) ? 10'd700 : 10'd3, "sofflush");
    check_expected("sofflush", 0, 1, 0, 1, 2, 1);

    // Random gapped traffic with a mid-frame reset.
    for (int c = 0; c < 800; c++) begin
      if (c == 150) begin
        @(negedge clk);
        sof = 1'b0;
        dval = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
      end
      case ($urandom_range(0, 3))
        0: d = 10'd0;
        1: d = 10'd1023;
        2: d = ($urandom_range(0, 1) == 1) ? 10'd512 : 10'd511;
        default: d = 10'($urandom_range(0, 1023));
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, d, "rand");
    end
    chk("rand.strobes_seen", (strobes - s0) > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
